// File: rtl/bp_be_loop_inference_sched_if.sv
// ----------------------------------------------------------------------------
// bp_be_loop_inference_sched_if
//
// Bundles the signals of the loop-inference scheduler into one interface.
// There are three groups:
//   requester side  : req_v_i, req_pc_i, req_confirm_i -> req_grant_o
//   inference unit  : li_start_o, li_pc_o, li_confirm_o, li_flush_o,
//                     li_yumi_o <-> li_v_i, li_count_i
//   response channel: resp_v_o, resp_id_o, resp_count_o, resp_timeout_o
//                     <- resp_yumi_i
// The _i/_o suffixes are named from the scheduler's point of view.
//
// Modports:
//   slave  - the scheduler itself
//   master - the environment (requesters, inference unit, response sink)
// ----------------------------------------------------------------------------
interface bp_be_loop_inference_sched_if #(
    parameter int num_req_p      = 4,
    parameter int vaddr_width_p  = 39,
    parameter int output_range_p = 8
);
    localparam int id_width_lp = $clog2(num_req_p);

    // Requester side
    logic [num_req_p-1:0]               req_v_i;
    logic [num_req_p*vaddr_width_p-1:0] req_pc_i;
    logic [num_req_p-1:0]               req_confirm_i;
    logic [num_req_p-1:0]               req_grant_o;

    // Inference unit side
    logic                               li_start_o;
    logic [vaddr_width_p-1:0]           li_pc_o;
    logic                               li_confirm_o;
    logic                               li_flush_o;
    logic                               li_v_i;
    logic [output_range_p-1:0]          li_count_i;
    logic                               li_yumi_o;

    // Response channel
    logic                               resp_v_o;
    logic [id_width_lp-1:0]             resp_id_o;
    logic [output_range_p-1:0]          resp_count_o;
    logic                               resp_timeout_o;
    logic                               resp_yumi_i;

    modport slave (
        input  req_v_i, req_pc_i, req_confirm_i,
        input  li_v_i, li_count_i,
        input  resp_yumi_i,
        output req_grant_o,
        output li_start_o, li_pc_o, li_confirm_o, li_flush_o, li_yumi_o,
        output resp_v_o, resp_id_o, resp_count_o, resp_timeout_o
    );

    modport master (
        output req_v_i, req_pc_i, req_confirm_i,
        output li_v_i, li_count_i,
        output resp_yumi_i,
        input  req_grant_o,
        input  li_start_o, li_pc_o, li_confirm_o, li_flush_o, li_yumi_o,
        input  resp_v_o, resp_id_o, resp_count_o, resp_timeout_o
    );
endinterface

// File: rtl/bp_be_loop_inference_sched.sv
// ----------------------------------------------------------------------------
// bp_be_loop_inference_sched
//
// This block shares one backend loop-inference unit among num_req_p
// striding-load requesters. It picks one requester at a time with a
// round-robin arbiter. It then drives the unit through start, confirm and
// result collection. Each discovery is limited to timeout_p cycles of waiting.
// When that limit runs out, the unit is flushed. The result goes back to the
// requester that owns it on a valid/yumi channel, tagged with that
// requester's id. Only one discovery is in flight at any time.
//
// Ports:
//   clk_i     - clock; all state changes on the rising edge
//   reset_n_i - asynchronous, active-low reset
//   io        - bp_be_loop_inference_sched_if.slave: requester, inference-unit
//               and response signals
// ----------------------------------------------------------------------------
module bp_be_loop_inference_sched #(
    parameter int vaddr_width_p  = 39,
    parameter int num_req_p      = 4,
    parameter int output_range_p = 8,
    parameter int timeout_p      = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_be_loop_inference_sched_if.slave   io
);

    localparam int id_width_lp    = $clog2(num_req_p);
    localparam int timer_width_lp = $clog2(timeout_p);

    localparam logic [id_width_lp-1:0]    id_last_lp    = id_width_lp'(num_req_p - 1);
    localparam logic [timer_width_lp-1:0] timer_last_lp = timer_width_lp'(timeout_p - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    logic [2:0]                state_r;
    logic [id_width_lp-1:0]    ptr_r;
    logic [id_width_lp-1:0]    id_r;
    logic [vaddr_width_p-1:0]  pc_r;
    logic [output_range_p-1:0] count_r;
    logic                      to_r;
    logic [timer_width_lp-1:0] timer_r;

    // Adds an offset to a requester index and wraps the sum at num_req_p.
    // This still works when num_req_p is not a power of two.
    function automatic logic [id_width_lp-1:0] wrap_add(
        input logic [id_width_lp-1:0] base,
        input int                     off
    );
        int sum;
        sum = int'(base) + off;
        if (sum >= num_req_p) sum -= num_req_p;
        return id_width_lp'(sum);
    endfunction

    // Round-robin pick: the first valid requester at or above ptr_r, wrapping.
    logic                   grant_v;
    logic [id_width_lp-1:0] grant_id;

    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path
        // leaves it unassigned and no latch is inferred.
        grant_v  = 1'b0;
        grant_id = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (!grant_v && io.req_v_i[wrap_add(ptr_r, k)]) begin
                grant_v  = 1'b1;
                grant_id = wrap_add(ptr_r, k);
            end
        end
    end

    logic in_idle, in_start, in_wait, in_flush, in_resp;
    assign in_idle  = (state_r == IDLE);
    assign in_start = (state_r == START);
    assign in_wait  = (state_r == WAIT);
    assign in_flush = (state_r == FLUSH);
    assign in_resp  = (state_r == RESP);

    assign io.req_grant_o = (in_idle && grant_v)
                          ? ({{(num_req_p-1){1'b0}}, 1'b1} << grant_id)
                          : '0;

    assign io.li_start_o   = in_start;
    assign io.li_pc_o      = pc_r;
    // Only the owner's confirm is forwarded. When the owner drops it, the
    // output drops too; the unit keeps any confirm it has already latched.
    assign io.li_confirm_o = in_wait && io.req_confirm_i[id_r];
    assign io.li_flush_o   = in_flush;
    assign io.li_yumi_o    = in_wait && io.li_v_i;

    // The response fields come straight from registers, so they stay stable
    // while the response is waiting for resp_yumi_i.
    assign io.resp_v_o       = in_resp;
    assign io.resp_id_o      = id_r;
    assign io.resp_count_o   = count_r;
    assign io.resp_timeout_o = to_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            id_r    <= '0;
            pc_r    <= '0;
            count_r <= '0;
            to_r    <= 1'b0;
            timer_r <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment, so every
            // branch below reads the values from before this clock edge.
            case (state_r)
                IDLE: begin
                    if (grant_v) begin
                        id_r    <= grant_id;
                        pc_r    <= io.req_pc_i[int'(grant_id)*vaddr_width_p +: vaddr_width_p];
                        state_r <= START;
                    end
                end
                START: begin
                    timer_r <= '0;
                    state_r <= WAIT;
                end
                WAIT: begin
                    timer_r <= timer_r + 1'b1;
                    // A result that arrives in the last allowed cycle wins
                    // over the timeout.
                    if (io.li_v_i) begin
                        count_r <= io.li_count_i;
                        to_r    <= 1'b0;
                        state_r <= RESP;
                    end else if (timer_r == timer_last_lp) begin
                        count_r <= '0;
                        to_r    <= 1'b1;
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    state_r <= RESP;
                end
                RESP: begin
                    if (io.resp_yumi_i) begin
                        ptr_r   <= (id_r == id_last_lp) ? '0 : id_r + 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
